nibble_serial_adder: RTL and testbench

Sequencer that performs a WIDTH-bit addition by reusing one `four_bit_adder` instance serially, one nibble per clock, least-significant nibble first. The block holds the inter-nibble carry in a register and presents operands and results over valid/ready handshakes. It trades latency for area, replacing a chain of WIDTH/4 adder instances with a single instance plus a small FSM.

---
 rtl/nibble_serial_adder.sv | 133 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one four_bit_adder reused once per clock, LS nibble first.
// Optional signed-overflow flag enabled by defining SERIAL_ADD_OVF_EN.

module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic             cout_reg;
    logic [CW-1:0]    cnt;
    logic [3:0]       s_nib;
    logic             fa_cout;

    four_bit_adder u_fa (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry),
        .s    (s_nib),
        .cout (fa_cout)
    );

`ifdef SERIAL_ADD_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            cnt      <= '0;
`ifdef SERIAL_ADD_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            ovf_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // sum_reg is left alone so the previous result stays visible
                    if (start_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
`ifdef SERIAL_ADD_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh     <= a_sh >> 4;
                    b_sh     <= b_sh >> 4;
                    sum_reg  <= {s_nib, sum_reg[WIDTH-1:4]};
                    carry    <= fa_cout;
                    cout_reg <= fa_cout;
                    cnt      <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
`ifdef SERIAL_ADD_OVF_EN
                        // s_nib[3] is the final sum MSB on the last step
                        ovf_reg <= (a_msb == b_msb) && (s_nib[3] != a_msb);
`endif
                    end
                end
                DONE: begin
                    if (result_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready  = (state == IDLE);
    assign result_valid = (state == DONE);
    assign busy         = (state == RUN) || (state == DONE);
    assign sum          = sum_reg;
    assign cout         = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf          = ovf_reg;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): spec vectors, corner
// sequences and randomized operations against an arithmetic reference model.

module tb_nibble_serial_adder;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int tests  = 0;
    int failed = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .cin          (cin),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sum          (sum),
        .cout         (cout),
`ifdef SERIAL_ADD_OVF_EN
        .ovf          (ovf),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain W+1 bit addition
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                            output time t_acc);
        int w;
        a = ta; b = tb_; cin = tc; start_valid = 1'b1;
        w = 0;
        while (!start_ready && w < 50) begin
            @(posedge clk); @(negedge clk); w++;
        end
        if (!start_ready) check("start_ready_timeout", 32'(start_ready), 32'd1);
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        start_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_result(input string name);
        int lat;
        lat = 0;
        while (!result_valid && lat < 30) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check({name, "_latency"}, 32'(lat), 32'(N));
    endtask

    task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, output time t_acc);
        logic [W:0] m;
        m = model(ta, tb_, tc);
        start_op(ta, tb_, tc, t_acc);
        wait_result(name);
        check({name, "_sum"}, 32'(sum), 32'(m[W-1:0]));
        check({name, "_cout"}, 32'(cout), 32'(m[W]));
        check({name, "_busy"}, 32'(busy), 32'd1);
        check({name, "_start_ready"}, 32'(start_ready), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check({name, "_ovf"}, 32'(ovf),
              32'((ta[W-1] == tb_[W-1]) && (m[W-1] != ta[W-1])));
`endif
    endtask

    initial begin
        vec_t         tbl[3];
        time          t1, t2;
        logic [W-1:0] hs;
        logic         hc;
        logic         seen;
        int           k;
        logic [W-1:0] ra, rb;
        logic         rc;

        tbl[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

        rst_n = 1'b0; start_valid = 1'b0; result_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors with constant expectations
        for (int i = 0; i < 3; i++) begin
            result_ready = 1'b1;
            start_op(tbl[i].a, tbl[i].b, tbl[i].cin, t1);
            wait_result($sformatf("vec%0d", i));
            check($sformatf("vec%0d_sum", i), 32'(sum), 32'(tbl[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(cout), 32'(tbl[i].cout));
            @(posedge clk); @(negedge clk);
            check($sformatf("vec%0d_idle_ready", i), 32'(start_ready), 32'd1);
            check($sformatf("vec%0d_idle_hold", i), 32'(sum), 32'(tbl[i].sum));
        end

        // Back-pressure: hold result_ready low, poke start_valid, outputs must not move
        result_ready = 1'b0;
        start_op(16'hFFFF, 16'hFFFF, 1'b1, t1);
        wait_result("bp");
        hs = sum; hc = cout;
        check("bp_sum", 32'(hs), 32'hFFFF);
        check("bp_cout", 32'(hc), 32'd1);
        for (int i = 0; i < 5; i++) begin
            a = 16'h1111; b = 16'h2222; start_valid = (i == 2);
            @(posedge clk); @(negedge clk);
            check("bp_valid", 32'(result_valid), 32'd1);
            check("bp_start_ready", 32'(start_ready), 32'd0);
            check("bp_sum_stable", 32'(sum), 32'hFFFF);
            check("bp_cout_stable", 32'(cout), 32'd1);
        end
        start_valid = 1'b0; result_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("bp_released_idle", 32'(start_ready), 32'd1);
        check("bp_released_busy", 32'(busy), 32'd0);
        check("bp_released_hold", 32'(sum), 32'hFFFF);

        // Reset during the 2nd RUN cycle
        start_op(16'h00FF, 16'h0001, 1'b0, t1);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_start_ready", 32'(start_ready), 32'd1);
        check("abort_result_valid", 32'(result_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        do_op("after_abort", 16'h0001, 16'h0001, 1'b0, t1);
        check("after_abort_exact", 32'(sum), 32'h0002);

        // Back-to-back with minimum initiation interval
        do_op("b2b_0", 16'h0010, 16'h0020, 1'b0, t1);
        check("b2b_0_exact", 32'(sum), 32'h0030);
        do_op("b2b_1", 16'h8000, 16'h8000, 1'b0, t2);
        check("b2b_1_exact", 32'(sum), 32'h0000);
        check("b2b_1_cout", 32'(cout), 32'd1);
        check("b2b_spacing", 32'((t2 - t1) / 10), 32'(N + 2));

`ifdef SERIAL_ADD_OVF_EN
        do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, t1);
        check("ovf_pos_exact", 32'(ovf), 32'd1);
        do_op("ovf_none", 16'hFFFF, 16'h0001, 1'b0, t1);
        check("ovf_none_exact", 32'(ovf), 32'd0);
`endif
        @(posedge clk); @(negedge clk);

        // Randomized operations with random back-pressure
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            if (i % 8 == 0) rb = ~ra;
            k = $urandom_range(0, 3);
            result_ready = 1'b0;
            do_op("rand", ra, rb, rc, t1);
            hs = sum; hc = cout;
            repeat (k) begin
                @(posedge clk); @(negedge clk);
                check("rand_hold_sum", 32'(sum), 32'(hs));
                check("rand_hold_valid", 32'(result_valid), 32'd1);
            end
            result_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            check("rand_idle", 32'(start_ready), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
